// File: rtl/axis_blk_hdr_engine.sv
// AXI-Stream header collector / result streamer around the bitcoin miner core.
// Optional framing check on s_axis_tlast enabled by defining HDR_TLAST_CHECK_EN.
module axis_blk_hdr_engine #(
   parameter int DATA_W   = 32,
   parameter int HDR_BITS = 640,
   parameter int RES_BITS = 288
) (
   input  logic                aclk,
   input  logic                areset,
   input  logic [DATA_W-1:0]   s_axis_tdata,
   input  logic                s_axis_tvalid,
   output logic                s_axis_tready,
   input  logic                s_axis_tlast,
   output logic [DATA_W-1:0]   m_axis_tdata,
   output logic                m_axis_tvalid,
   input  logic                m_axis_tready,
   output logic                m_axis_tlast,
   output logic [HDR_BITS-1:0] miner_hdr,
   output logic                miner_start,
   input  logic                miner_done,
   input  logic [RES_BITS-1:0] miner_result,
   output logic                busy,
   output logic                hdr_err
);

   localparam int N_HDR = HDR_BITS / DATA_W;
   localparam int N_RES = RES_BITS / DATA_W;
   localparam int HW    = (N_HDR > 1) ? $clog2(N_HDR) : 1;
   localparam int RW    = (N_RES > 1) ? $clog2(N_RES) : 1;
   localparam logic [HW-1:0] HDR_LAST = HW'(N_HDR - 1);
   localparam logic [RW-1:0] RES_LAST = RW'(N_RES - 1);

   typedef enum logic [1:0] {COLLECT, START, WAIT_DONE, SEND} state_t;

   state_t              state;
   logic [HW-1:0]       cnt;
   logic [RW-1:0]       j;
   logic [HDR_BITS-1:0] hdr_q;
   logic [RES_BITS-1:0] out_q;
   logic                hdr_beat;

   // Ready is gated by areset so nothing handshakes while reset is held.
   assign s_axis_tready = (state == COLLECT) && !areset;
   assign hdr_beat      = s_axis_tvalid && s_axis_tready;
   assign miner_start   = (state == START);
   assign busy          = (state != COLLECT);
   assign m_axis_tvalid = (state == SEND);
   assign m_axis_tlast  = (state == SEND) && (j == RES_LAST);
   assign m_axis_tdata  = out_q[DATA_W-1:0];
   assign miner_hdr     = hdr_q;

`ifdef HDR_TLAST_CHECK_EN
   logic err_q;
   assign hdr_err = err_q;
`else
   logic unused_tlast;
   assign unused_tlast = s_axis_tlast;
   assign hdr_err      = 1'b0;
`endif

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state <= COLLECT;
         cnt   <= '0;
         j     <= '0;
         hdr_q <= '0;
         out_q <= '0;
`ifdef HDR_TLAST_CHECK_EN
         err_q <= 1'b0;
`endif
      end else begin
`ifdef HDR_TLAST_CHECK_EN
         err_q <= 1'b0;
`endif
         case (state)
            COLLECT: begin
               if (hdr_beat) begin
                  hdr_q[int'(cnt)*DATA_W +: DATA_W] <= s_axis_tdata;
`ifdef HDR_TLAST_CHECK_EN
                  if (s_axis_tlast != (cnt == HDR_LAST)) begin
                     cnt   <= '0;
                     err_q <= 1'b1;
                  end else
`endif
                  if (cnt == HDR_LAST) begin
                     cnt   <= '0;
                     state <= START;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            START: state <= WAIT_DONE;
            WAIT_DONE: begin
               if (miner_done) begin
                  out_q <= miner_result;
                  j     <= '0;
                  state <= SEND;
               end
            end
            SEND: begin
               // Result is shifted down so the current beat always sits in the low word.
               if (m_axis_tready) begin
                  out_q <= out_q >> DATA_W;
                  if (j == RES_LAST) begin
                     j     <= '0;
                     state <= COLLECT;
                  end else begin
                     j <= j + 1'b1;
                  end
               end
            end
            default: state <= COLLECT;
         endcase
      end
   end

endmodule

// File: tb/tb_axis_blk_hdr_engine.sv
// Self-checking bench for axis_blk_hdr_engine: default 32-bit instance plus a 64-bit/320-bit instance.
module tb_axis_blk_hdr_engine;

   localparam int DW = 32, HB = 640, RB = 288, NH = HB / DW, NR = RB / DW;
   localparam int DW2 = 64, RB2 = 320, NH2 = HB / DW2, NR2 = RB2 / DW2;

   logic          aclk, areset;
   logic [DW-1:0] s_tdata, m_tdata;
   logic          s_tvalid, s_tready, s_tlast, m_tvalid, m_tready, m_tlast;
   logic [HB-1:0] mhdr;
   logic          mstart, mdone, busy, herr;
   logic [RB-1:0] mres;

   logic [DW2-1:0] w_s_tdata, w_m_tdata;
   logic           w_s_tvalid, w_s_tready, w_s_tlast, w_m_tvalid, w_m_tready, w_m_tlast;
   logic [HB-1:0]  w_mhdr;
   logic           w_mstart, w_mdone, w_busy, w_herr;
   logic [RB2-1:0] w_mres;

   int ncomp = 0, nfail = 0;
   int start_cnt = 0, err_cnt = 0;
   logic [DW-1:0]  hw  [40];
   logic [DW2-1:0] hww [NH2];

   axis_blk_hdr_engine dut (
      .aclk(aclk), .areset(areset),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
      .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
      .miner_hdr(mhdr), .miner_start(mstart), .miner_done(mdone), .miner_result(mres),
      .busy(busy), .hdr_err(herr)
   );

   axis_blk_hdr_engine #(.DATA_W(DW2), .HDR_BITS(HB), .RES_BITS(RB2)) dut_w (
      .aclk(aclk), .areset(areset),
      .s_axis_tdata(w_s_tdata), .s_axis_tvalid(w_s_tvalid), .s_axis_tready(w_s_tready), .s_axis_tlast(w_s_tlast),
      .m_axis_tdata(w_m_tdata), .m_axis_tvalid(w_m_tvalid), .m_axis_tready(w_m_tready), .m_axis_tlast(w_m_tlast),
      .miner_hdr(w_mhdr), .miner_start(w_mstart), .miner_done(w_mdone), .miner_result(w_mres),
      .busy(w_busy), .hdr_err(w_herr)
   );

   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   always @(negedge aclk) begin
      if (mstart) start_cnt++;
      if (herr) err_cnt++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   function automatic logic [HB-1:0] hdr_model(input int base);
      logic [HB-1:0] h;
      h = '0;
      for (int k = 0; k < NH; k++) h[k*DW +: DW] = hw[base + k];
      return h;
   endfunction

   function automatic logic [RB-1:0] rand_res();
      logic [RB-1:0] r;
      for (int k = 0; k < NR; k++) r[k*32 +: 32] = $urandom;
      return r;
   endfunction

   // Drive hw[first .. first+n-1] with random idle gaps; tlast on absolute index tlast_at.
   task automatic send_beats(input int first, input int n, input int tlast_at);
      int w;
      for (int k = first; k < first + n; k++) begin
         s_tvalid = 1'b0;
         repeat ($urandom_range(0, 2)) step();
         s_tdata  = hw[k];
         s_tlast  = (k == tlast_at);
         s_tvalid = 1'b1;
         w = 0;
         while (!s_tready && w < 50) begin step(); w++; end
         if (!s_tready) begin
            ncomp++; nfail++;
            $display("FAIL send_timeout: beat %0d tready got %b want 1", k, s_tready);
         end
         step();
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   // mode 0: tready 2 low / 6 high repeating; mode 1: random tready.
   task automatic recv_result(input logic [RB-1:0] exp, input int mode);
      int j, c;
      j = 0; c = 0;
      while (j < NR && c < 500) begin
         m_tready = (mode == 0) ? ((c % 8) >= 2) : 1'($urandom_range(0, 1));
         ncomp++;
         if ({m_tvalid, m_tdata, m_tlast} !== {1'b1, exp[j*DW +: DW], (j == NR - 1)}) begin
            nfail++;
            $display("FAIL result_beat%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                     j, m_tvalid, m_tdata, m_tlast, exp[j*DW +: DW], (j == NR - 1));
         end
         if (m_tready) j++;
         step();
         c++;
      end
      m_tready = 1'b0;
      ncomp++;
      if (j != NR || m_tvalid !== 1'b0 || busy !== 1'b0 || s_tready !== 1'b1) begin
         nfail++;
         $display("FAIL result_end: got beats=%0d v=%b busy=%b rdy=%b want beats=%0d v=0 busy=0 rdy=1",
                  j, m_tvalid, busy, s_tready, NR);
      end
   endtask

   task automatic finish_run();
      logic [RB-1:0] exp;
      if (mstart) step();
      exp   = rand_res();
      mres  = exp;
      mdone = 1'b1;
      step();
      mdone = 1'b0;
      mres  = rand_res();
      recv_result(exp, 1);
   endtask

   task automatic do_reset(input string tag);
      areset = 1'b1;
      #1;
      ncomp++;
      if ({s_tready, busy, m_tvalid, m_tlast, mstart, herr} !== 6'b0 || mhdr !== '0 || m_tdata !== '0) begin
         nfail++;
         $display("FAIL %s_outputs: got rdy=%b busy=%b v=%b l=%b st=%b err=%b hdr0=%b d=%h want all 0",
                  tag, s_tready, busy, m_tvalid, m_tlast, mstart, herr, (mhdr == '0), m_tdata);
      end
      @(posedge aclk);
      #1;
      areset = 1'b0;
      step();
      ncomp++;
      if (s_tready !== 1'b1 || busy !== 1'b0) begin
         nfail++;
         $display("FAIL %s_release: got rdy=%b busy=%b want rdy=1 busy=0", tag, s_tready, busy);
      end
   endtask

   task automatic test_reset();
      step();
      ncomp++;
      if ({s_tready, busy, m_tvalid, m_tlast, mstart, herr} !== 6'b0 || mhdr !== '0 || m_tdata !== '0) begin
         nfail++;
         $display("FAIL reset_outputs: got rdy=%b busy=%b v=%b l=%b st=%b err=%b d=%h want all 0",
                  s_tready, busy, m_tvalid, m_tlast, mstart, herr, m_tdata);
      end
      step();
      areset = 1'b0;
      step();
      ncomp++;
      if (s_tready !== 1'b1 || busy !== 1'b0) begin
         nfail++;
         $display("FAIL reset_release: got rdy=%b busy=%b want rdy=1 busy=0", s_tready, busy);
      end
   endtask

   task automatic test_header();
      int s0;
      s0 = start_cnt;
      hw[0] = 32'h02000000;
      for (int k = 1; k < 17; k++) hw[k] = $urandom;
      hw[17] = 32'h74749054; hw[18] = 32'h747B1B18; hw[19] = 32'h43F740C0;
      send_beats(0, NH - 1, NH - 1);
      ncomp++;
      if (busy !== 1'b0 || mstart !== 1'b0 || s_tready !== 1'b1) begin
         nfail++;
         $display("FAIL hdr_partial: got busy=%b st=%b rdy=%b want 0 0 1", busy, mstart, s_tready);
      end
      send_beats(NH - 1, 1, NH - 1);
      ncomp++;
      if (mstart !== 1'b1 || busy !== 1'b1 || s_tready !== 1'b0) begin
         nfail++;
         $display("FAIL hdr_start: got st=%b busy=%b rdy=%b want 1 1 0", mstart, busy, s_tready);
      end
      ncomp++;
      if (mhdr !== hdr_model(0)) begin
         nfail++;
         $display("FAIL hdr_value: got %h want %h", mhdr, hdr_model(0));
      end
      ncomp++;
      if (mhdr[31:0] !== 32'h02000000 || mhdr[639:608] !== 32'h43F740C0) begin
         nfail++;
         $display("FAIL hdr_ends: got %h/%h want 02000000/43f740c0", mhdr[31:0], mhdr[639:608]);
      end
      step();
      ncomp++;
      if (mstart !== 1'b0 || busy !== 1'b1 || start_cnt - s0 != 1) begin
         nfail++;
         $display("FAIL hdr_pulse: got st=%b busy=%b pulses=%0d want 0 1 1", mstart, busy, start_cnt - s0);
      end
   endtask

   task automatic test_result();
      logic [RB-1:0] exp;
      exp = rand_res();
      exp[31:0] = 32'h43F740C0;
      mres = exp;
      repeat (5) begin
         ncomp++;
         if (m_tvalid !== 1'b0) begin
            nfail++;
            $display("FAIL wait_novalid: got %b want 0", m_tvalid);
         end
         step();
      end
      mdone = 1'b1;
      step();
      mdone = 1'b0;
      mres  = rand_res();
      ncomp++;
      if (m_tvalid !== 1'b1 || m_tdata !== 32'h43F740C0) begin
         nfail++;
         $display("FAIL result_first: got v=%b d=%h want v=1 d=43f740c0", m_tvalid, m_tdata);
      end
      recv_result(exp, 0);
      ncomp++;
      if (mhdr !== hdr_model(0)) begin
         nfail++;
         $display("FAIL hdr_stable: got %h want %h", mhdr, hdr_model(0));
      end
      mdone = 1'b1;
      repeat (3) begin
         step();
         ncomp++;
         if (m_tvalid !== 1'b0 || busy !== 1'b0) begin
            nfail++;
            $display("FAIL done_in_collect: got v=%b busy=%b want 0 0", m_tvalid, busy);
         end
      end
      mdone = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [RB-1:0] r [2];
      int idx, nst, rf, j, timer, cyc;
      logic acc;
      for (int k = 0; k < 40; k++) hw[k] = $urandom;
      r[0] = rand_res(); r[1] = rand_res();
      idx = 0; nst = 0; rf = 0; j = 0; timer = 0; cyc = 0;
      while (rf < 2 && cyc < 3000) begin
         s_tvalid = (idx < 40);
         s_tdata  = hw[idx % 40];
         s_tlast  = ((idx % NH) == NH - 1);
         ncomp++;
         if (s_tready && busy) begin
            nfail++;
            $display("FAIL b2b_ready_busy: got rdy=1 busy=1 want rdy=0 when busy");
         end
         if (mstart) begin
            ncomp++;
            if (nst > 1 || mhdr !== hdr_model(nst * NH)) begin
               nfail++;
               $display("FAIL b2b_hdr%0d: got %h", nst, mhdr);
            end
            if (nst < 2) nst++;
            timer = $urandom_range(1, 6);
         end else if (timer > 0) begin
            timer--;
            if (timer == 0) begin
               mdone = 1'b1;
               mres  = r[nst - 1];
            end
         end
         m_tready = 1'($urandom_range(0, 1));
         if (m_tvalid) begin
            mdone = 1'b0;
            ncomp++;
            if (m_tdata !== r[rf][j*DW +: DW] || m_tlast !== (j == NR - 1)) begin
               nfail++;
               $display("FAIL b2b_res%0d_beat%0d: got d=%h l=%b want d=%h l=%b",
                        rf, j, m_tdata, m_tlast, r[rf][j*DW +: DW], (j == NR - 1));
            end
            if (m_tready) begin
               if (j == NR - 1) begin
                  if (rf == 0) begin
                     ncomp++;
                     if (idx != NH) begin
                        nfail++;
                        $display("FAIL b2b_accepted: got %0d beats want %0d", idx, NH);
                     end
                  end
                  j = 0;
                  rf++;
               end else begin
                  j++;
               end
            end
         end
         acc = s_tvalid && s_tready;
         step();
         cyc++;
         if (acc) idx++;
      end
      s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0; mdone = 1'b0;
      ncomp++;
      if (rf != 2 || nst != 2 || idx != 40) begin
         nfail++;
         $display("FAIL b2b_done: got results=%0d starts=%0d beats=%0d want 2 2 40", rf, nst, idx);
      end
   endtask

   task automatic test_reset_mid();
      logic [RB-1:0] exp;
      for (int k = 0; k < NH; k++) hw[k] = $urandom;
      send_beats(0, 7, NH - 1);
      do_reset("rst_collect");
      for (int k = 0; k < NH; k++) hw[k] = $urandom;
      send_beats(0, NH, NH - 1);
      ncomp++;
      if (mstart !== 1'b1 || mhdr !== hdr_model(0)) begin
         nfail++;
         $display("FAIL rst_next_hdr: got st=%b hdr=%h want st=1 hdr=%h", mstart, mhdr, hdr_model(0));
      end
      step();
      exp = rand_res();
      mres = exp; mdone = 1'b1;
      step();
      mdone = 1'b0;
      m_tready = 1'b1;
      for (int b = 0; b < 3; b++) begin
         ncomp++;
         if (m_tvalid !== 1'b1 || m_tdata !== exp[b*DW +: DW]) begin
            nfail++;
            $display("FAIL rst_partial_beat%0d: got v=%b d=%h want v=1 d=%h", b, m_tvalid, m_tdata, exp[b*DW +: DW]);
         end
         step();
      end
      m_tready = 1'b0;
      do_reset("rst_send");
      m_tready = 1'b1;
      repeat (4) begin
         step();
         ncomp++;
         if (m_tvalid !== 1'b0 || busy !== 1'b0) begin
            nfail++;
            $display("FAIL rst_stale: got v=%b busy=%b want 0 0", m_tvalid, busy);
         end
      end
      m_tready = 1'b0;
      for (int k = 0; k < NH; k++) hw[k] = $urandom;
      send_beats(0, NH, NH - 1);
      ncomp++;
      if (mstart !== 1'b1 || mhdr !== hdr_model(0)) begin
         nfail++;
         $display("FAIL rst_recover_hdr: got st=%b hdr=%h", mstart, mhdr);
      end
      finish_run();
   endtask

   task automatic test_tlast();
      int s0, e0;
      s0 = start_cnt; e0 = err_cnt;
      for (int k = 0; k < NH; k++) hw[k] = $urandom;
`ifdef HDR_TLAST_CHECK_EN
      send_beats(0, 10, 9);
      ncomp++;
      if (herr !== 1'b1 || busy !== 1'b0 || mstart !== 1'b0) begin
         nfail++;
         $display("FAIL tlast_early: got err=%b busy=%b st=%b want 1 0 0", herr, busy, mstart);
      end
      step();
      ncomp++;
      if (herr !== 1'b0) begin
         nfail++;
         $display("FAIL tlast_pulse: got err=%b want 0", herr);
      end
      send_beats(0, NH, -1);
      ncomp++;
      if (herr !== 1'b1 || busy !== 1'b0 || mstart !== 1'b0) begin
         nfail++;
         $display("FAIL tlast_missing: got err=%b busy=%b st=%b want 1 0 0", herr, busy, mstart);
      end
      step();
      for (int k = 0; k < NH; k++) hw[k] = $urandom;
      send_beats(0, NH, NH - 1);
      ncomp++;
      if (mstart !== 1'b1 || mhdr !== hdr_model(0) || err_cnt - e0 != 2 || start_cnt - s0 != 0) begin
         nfail++;
         $display("FAIL tlast_good: got st=%b errs=%0d starts=%0d want st=1 errs=2 starts=0",
                  mstart, err_cnt - e0, start_cnt - s0);
      end
`else
      send_beats(0, 10, 9);
      ncomp++;
      if (herr !== 1'b0 || busy !== 1'b0) begin
         nfail++;
         $display("FAIL tlast_ignored: got err=%b busy=%b want 0 0", herr, busy);
      end
      send_beats(10, NH - 10, -1);
      ncomp++;
      if (mstart !== 1'b1 || mhdr !== hdr_model(0) || err_cnt - e0 != 0) begin
         nfail++;
         $display("FAIL tlast_count_frame: got st=%b errs=%0d want st=1 errs=0", mstart, err_cnt - e0);
      end
`endif
      finish_run();
   endtask

   task automatic test_wide();
      logic [RB2-1:0] wres;
      logic [HB-1:0]  whdr;
      int w;
      for (int k = 0; k < NH2; k++) begin
         hww[k] = {$urandom, $urandom};
         whdr[k*DW2 +: DW2] = hww[k];
      end
      for (int k = 0; k < NH2; k++) begin
         w_s_tdata = hww[k]; w_s_tlast = (k == NH2 - 1); w_s_tvalid = 1'b1;
         w = 0;
         while (!w_s_tready && w < 50) begin step(); w++; end
         if (!w_s_tready) begin
            ncomp++; nfail++;
            $display("FAIL wide_send_timeout: beat %0d", k);
         end
         step();
      end
      w_s_tvalid = 1'b0; w_s_tlast = 1'b0;
      ncomp++;
      if (w_mstart !== 1'b1 || w_mhdr !== whdr || w_herr !== 1'b0) begin
         nfail++;
         $display("FAIL wide_hdr: got st=%b err=%b hdr=%h want st=1 err=0 hdr=%h", w_mstart, w_herr, w_mhdr, whdr);
      end
      step();
      for (int k = 0; k < RB2 / 32; k++) wres[k*32 +: 32] = $urandom;
      w_mres = wres; w_mdone = 1'b1;
      step();
      w_mdone = 1'b0;
      w_m_tready = 1'b1;
      for (int j = 0; j < NR2; j++) begin
         ncomp++;
         if ({w_m_tvalid, w_m_tdata, w_m_tlast} !== {1'b1, wres[j*DW2 +: DW2], (j == NR2 - 1)}) begin
            nfail++;
            $display("FAIL wide_beat%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                     j, w_m_tvalid, w_m_tdata, w_m_tlast, wres[j*DW2 +: DW2], (j == NR2 - 1));
         end
         step();
      end
      w_m_tready = 1'b0;
      ncomp++;
      if (w_m_tvalid !== 1'b0 || w_busy !== 1'b0) begin
         nfail++;
         $display("FAIL wide_end: got v=%b busy=%b want 0 0", w_m_tvalid, w_busy);
      end
   endtask

   initial begin
      areset = 1'b1;
      s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0; mdone = 1'b0; mres = '0;
      w_s_tdata = '0; w_s_tvalid = 1'b0; w_s_tlast = 1'b0; w_m_tready = 1'b0; w_mdone = 1'b0; w_mres = '0;
      test_reset();
      test_header();
      test_result();
      test_back_to_back();
      test_reset_mid();
      test_tlast();
      test_wide();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
      $finish;
   end

endmodule
